axilite_master_arbiter: RTL and testbench
=========================================

# axilite_master_arbiter

Shares one AXI-Lite master backend port (start/done pulse interface) between NUM_REQ independent requesters. Sits between user-side register clients and the AXI-Lite master. It arbitrates round-robin, captures the winner's command, and issues exactly one backend write or read pulse. It then waits for the matching done pulse and returns a one-cycle response to the owning requester, with read data for reads. Only one transaction is outstanding at any time.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8. IDW = $clog2(NUM_REQ).
- axi_aclk  in  1  clock; all logic on rising edge.
- axi_aresetn  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until that requester's req_ready.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*32  packed addresses; requester i uses bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data; ignored for reads.
- req_wstrb  in  NUM_REQ*4  packed byte strobes; ignored for reads.
- req_ready  out  NUM_REQ  one-hot, combinational; command accepted this cycle.
- resp_valid  out  NUM_REQ  one-hot, registered one-cycle completion pulse.
- resp_rdata  out  32  read data; valid while resp_valid is high after a read; holds its value otherwise.
- busy  out  1  high in every state except IDLE.
- grant_id  out  IDW  index of current or last owner.
- bk_wstart, bk_rstart  out  1  one-cycle backend start pulses.
- bk_waddr, bk_wdata  out  32; bk_wstrb  out  4; bk_raddr  out  32  backend command fields.
- bk_wdone, bk_rdone  in  1  backend completion pulses.
- bk_rdata  in  32  backend read data; valid in the bk_rdone cycle.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, select the winner g and drive req_ready[g]=1 combinationally in the same cycle.
  - Register g into grant_id. Register req_we[g], addr, wdata and wstrb into cmd registers.
  - Move to ISSUE.
- Round-robin selection: search starts at (grant_id+1) mod NUM_REQ and wraps; the first set req_valid bit wins.
- ISSUE:
  - Drive bk_wstart=1 if the cmd is a write, else bk_rstart=1, for exactly one cycle.
  - Move to WAIT.
- bk_waddr, bk_wdata, bk_wstrb and bk_raddr are driven continuously from the cmd registers. The unused direction's fields read as 0.
- WAIT:
  - Write cmd: on bk_wdone move to RESP.
  - Read cmd: on bk_rdone capture bk_rdata into resp_rdata, then move to RESP.
  - A done pulse of the wrong type is ignored.
- RESP: drive resp_valid[grant_id]=1 for one cycle, then move to IDLE.
- Done pulses arriving in IDLE, ISSUE or RESP are ignored.
- Requester rules:
  - Fields are sampled only in the req_ready cycle.
  - A requester may deassert req_valid, or present a new request, from the next cycle on.
  - A requester still asserting req_valid after its response is re-arbitrated normally.
- No new request is accepted until the current transaction returns to IDLE.

## Timing
- Reset values:
  - state=IDLE, grant_id=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0, resp_valid=0, resp_rdata=0, busy=0.
  - bk_wstart=0, bk_rstart=0, all bk_* addr/data/strb outputs=0, cmd registers=0.
- Accept cycle T: request seen in IDLE, req_ready high in T.
- T+1: bk_*start pulse.
- Done pulse at cycle D (D >= T+2): resp_valid high at D+1.
- Back-to-back: the next req_ready can occur at D+2, giving a minimum of 4 cycles per transaction plus backend latency.
- Reset asserted mid-transaction aborts it: no resp_valid is generated, and the state returns to IDLE on the next edge.
  - The backend master shares axi_aresetn and is reset together with this block.
- With simultaneous requests, each requester is served once per NUM_REQ grants; starvation is impossible.

## Configuration
- AXIL_ARB_FIXED_PRIO_EN defined: selection is fixed priority, and the lowest-index asserted req_valid always wins. grant_id still records the owner.
- Macro undefined (default): round-robin selection as described in Operation.

## Test plan
- Single write from req 1 (addr 0x3000_0010, data 0xDEAD_BEEF, strb 0xF), done 5 cycles after start:
  - bk_wstart with those exact fields one cycle after req_ready[1].
  - resp_valid=4'b0010 one cycle after bk_wdone.
- Single read from req 2, bk_rdata=0x1234_5678 at bk_rdone: resp_valid[2] pulses with resp_rdata=0x1234_5678.
- All 4 requesters assert continuously after reset:
  - Default build: grant order 0,1,2,3,0,...
  - AXIL_ARB_FIXED_PRIO_EN build: always 0.
- bk_rdone injected during a write WAIT, plus spurious bk_wdone in IDLE: both ignored; the write still completes on bk_wdone.
- Reset pulsed in WAIT: the following cycle shows busy=0, no resp_valid, and all outputs at reset values; the next request is then serviced normally.

Source files
------------

// File: rtl/axilite_master_arbiter.sv
// axilite_master_arbiter: round-robin sharing of one AXI-Lite master backend.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module axilite_master_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   bk_wstart,
    output logic                   bk_rstart,
    output logic [31:0]            bk_waddr,
    output logic [31:0]            bk_wdata,
    output logic [3:0]             bk_wstrb,
    output logic [31:0]            bk_raddr,
    input  logic                   bk_wdone,
    input  logic                   bk_rdone,
    input  logic [31:0]            bk_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic               cmd_we_q, cmd_we_d;
    logic [31:0]        cmd_addr_q, cmd_addr_d;
    logic [31:0]        cmd_wdata_q, cmd_wdata_d;
    logic [3:0]         cmd_wstrb_q, cmd_wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [NUM_REQ-1:0] resp_q, resp_d;
    logic               any_req;
    logic [IDW-1:0]     win;
    int                 idx;

    // Select the next owner; scanning downwards leaves the first hit in win.
    always_comb begin
        win     = grant_q;
        any_req = 1'b0;
        idx     = 0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win     = IDW'(i);
                any_req = 1'b1;
            end
        end
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                win     = IDW'(idx);
                any_req = 1'b1;
            end
        end
`endif
    end

    // Transaction FSM: accept, issue one start pulse, wait for done, respond.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wstrb_d = cmd_wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = '0;
        req_ready   = '0;
        bk_wstart   = 1'b0;
        bk_rstart   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready[win] = 1'b1;
                    grant_d        = win;
                    cmd_we_d       = req_we[win];
                    cmd_addr_d     = req_addr[{win, 5'd0} +: 32];
                    cmd_wdata_d    = req_wdata[{win, 5'd0} +: 32];
                    cmd_wstrb_d    = req_wstrb[{win, 2'd0} +: 4];
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                bk_wstart = cmd_we_q;
                bk_rstart = ~cmd_we_q;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cmd_we_q && bk_wdone) begin
                    resp_d[grant_q] = 1'b1;
                    state_d         = RESP;
                end else if (!cmd_we_q && bk_rdone) begin
                    rdata_d         = bk_rdata;
                    resp_d[grant_q] = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers with synchronous active-low reset.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            grant_q     <= IDW'(NUM_REQ - 1);
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wstrb_q <= cmd_wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign resp_valid = resp_q;
    assign resp_rdata = rdata_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign bk_waddr   = cmd_we_q ? cmd_addr_q  : '0;
    assign bk_wdata   = cmd_we_q ? cmd_wdata_q : '0;
    assign bk_wstrb   = cmd_we_q ? cmd_wstrb_q : '0;
    assign bk_raddr   = cmd_we_q ? '0 : cmd_addr_q;

endmodule

// File: tb/tb_axilite_master_arbiter.sv
// tb_axilite_master_arbiter: vector table, corner sequences and a randomized
// run against a transaction-level arbitration model.
module tb_axilite_master_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_rdata;
    logic            busy;
    logic [1:0]      grant_id;
    logic            bk_wstart, bk_rstart;
    logic [31:0]     bk_waddr, bk_wdata, bk_raddr;
    logic [3:0]      bk_wstrb;
    logic            bk_wdone, bk_rdone;
    logic [31:0]     bk_rdata;

    axilite_master_arbiter #(.NUM_REQ(N)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rstn),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .busy        (busy),
        .grant_id    (grant_id),
        .bk_wstart   (bk_wstart),
        .bk_rstart   (bk_rstart),
        .bk_waddr    (bk_waddr),
        .bk_wdata    (bk_wdata),
        .bk_wstrb    (bk_wstrb),
        .bk_raddr    (bk_raddr),
        .bk_wdone    (bk_wdone),
        .bk_rdone    (bk_rdone),
        .bk_rdata    (bk_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // requester-side state, as the requesters present it
    logic        pend   [N];
    logic        p_we   [N];
    logic [31:0] p_addr [N];
    logic [31:0] p_wdata[N];
    logic [3:0]  p_wstrb[N];

    // reference model state
    int          last_g;
    logic [31:0] rd_model;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] bk_rd;
        bit          noise;
        logic [N-1:0] exp_oh;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend[i];
            req_we[i]            = p_we[i];
            req_addr[32*i +: 32] = p_addr[i];
            req_wdata[32*i +: 32] = p_wdata[i];
            req_wstrb[4*i +: 4]  = p_wstrb[i];
        end
    endtask

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        p_we[i]    = 1'($urandom_range(0, 1));
        p_addr[i]  = $urandom;
        p_wdata[i] = $urandom;
        p_wstrb[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        pend[i]    = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = a;
        p_wdata[i] = d;
        p_wstrb[i] = s;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // winner from the arbitration rule itself
    function automatic int pick(input int lg);
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (pend[i]) return i;
        end
`else
        for (int k = 1; k <= N; k++) begin
            if (pend[(lg + k) % N]) return (lg + k) % N;
        end
`endif
        return 0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp"}, 32'(resp_valid), 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'(N - 1));
        chk({tag, "_starts"}, 32'({bk_wstart, bk_rstart}), 32'd0);
        chk({tag, "_waddr"}, bk_waddr, 32'd0);
        chk({tag, "_wdata"}, bk_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(bk_wstrb), 32'd0);
        chk({tag, "_raddr"}, bk_raddr, 32'd0);
    endtask

    // One full transaction; DUT is in RESP or IDLE-bound on entry.
    task automatic do_txn(input int id, input logic [N-1:0] exp_oh,
                          input int lat, input logic [31:0] rd,
                          input logic [31:0] exp_rd, input bit keep,
                          input bit noise);
        logic        we;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        tick();
        drive();
        bk_wdone = noise;
        bk_rdone = 1'b0;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(exp_oh));
        chk("accept_busy", 32'(busy), 32'd0);
        we = p_we[id];
        a  = p_addr[id];
        wd = p_wdata[id];
        ws = p_wstrb[id];
        pend[id] = 1'b0;
        if (keep) new_req(id);
        last_g = id;
        tick();
        drive();
        bk_wdone = noise && we;
        bk_rdone = noise && !we;
        bk_rdata = $urandom;
        #1;
        chk("start_w", 32'(bk_wstart), 32'(we));
        chk("start_r", 32'(bk_rstart), 32'(!we));
        chk("start_waddr", bk_waddr, we ? a : 32'd0);
        chk("start_wdata", bk_wdata, we ? wd : 32'd0);
        chk("start_wstrb", 32'(bk_wstrb), we ? 32'(ws) : 32'd0);
        chk("start_raddr", bk_raddr, we ? 32'd0 : a);
        chk("start_grant", 32'(grant_id), 32'(id));
        chk("start_ready", 32'(req_ready), 32'd0);
        for (int i = 1; i < lat; i++) begin
            tick();
            bk_wdone = noise && (i == 1) && !we;
            bk_rdone = noise && (i == 1) && we;
            bk_rdata = $urandom;
            #1;
            chk("wait_resp", 32'(resp_valid), 32'd0);
            chk("wait_starts", 32'({bk_wstart, bk_rstart}), 32'd0);
            chk("wait_ready", 32'(req_ready), 32'd0);
        end
        tick();
        bk_wdone = we;
        bk_rdone = !we;
        bk_rdata = rd;
        #1;
        chk("done_resp", 32'(resp_valid), 32'd0);
        tick();
        bk_wdone = 1'b0;
        bk_rdone = 1'b0;
        bk_rdata = $urandom;
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_oh));
        if (!we) rd_model = exp_rd;
        chk("resp_rdata", resp_rdata, rd_model);
        chk("resp_busy", 32'(busy), 32'd1);
        chk("resp_ready", 32'(req_ready), 32'd0);
    endtask

    vec_t vecs[6];
    int   exp_order[8];

    initial begin
        vecs[0] = '{1, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 5,
                    32'h0, 1'b0, 4'b0010, 32'h0};
        vecs[1] = '{2, 1'b0, 32'h4000_0020, 32'h0, 4'h0, 3,
                    32'h1234_5678, 1'b0, 4'b0100, 32'h1234_5678};
        vecs[2] = '{0, 1'b1, 32'h0000_0004, 32'h0000_00A5, 4'h3, 1,
                    32'hFFFF_FFFF, 1'b0, 4'b0001, 32'h1234_5678};
        vecs[3] = '{3, 1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'h8, 4,
                    32'h0, 1'b1, 4'b1000, 32'h1234_5678};
        vecs[4] = '{3, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 3,
                    32'hA5A5_0001, 1'b1, 4'b1000, 32'hA5A5_0001};
        vecs[5] = '{0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1,
                    32'h0BAD_CAFE, 1'b0, 4'b0001, 32'h0BAD_CAFE};

        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0;
            p_wdata[i] = '0; p_wstrb[i] = '0;
        end
        drive();
        bk_wdone = 1'b0;
        bk_rdone = 1'b0;
        bk_rdata = '0;
        rstn     = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        chk_reset_outputs("reset");
        last_g   = N - 1;
        rd_model = '0;

        // all requesters held continuously
        for (int k = 0; k < 8; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            exp_order[k] = 0;
`else
            exp_order[k] = k % N;
`endif
        end
        for (int i = 0; i < N; i++) new_req(i);
        for (int k = 0; k < 8; k++) begin
            do_txn(exp_order[k], onehot(exp_order[k]), 2, 32'hC0DE_0000 + k,
                   32'hC0DE_0000 + k, 1'b1, 1'b0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        // directed vector table, one requester at a time
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                    vecs[v].wstrb);
            do_txn(vecs[v].id, vecs[v].exp_oh, vecs[v].lat, vecs[v].bk_rd,
                   vecs[v].exp_rd, 1'b0, vecs[v].noise);
        end

        // reset pulsed while waiting for the backend
        set_req(1, 1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF);
        tick(); drive(); #1;
        chk("rstw_ready", 32'(req_ready), 32'b0010);
        pend[1] = 1'b0;
        tick(); drive(); #1;
        chk("rstw_start", 32'(bk_wstart), 32'd1);
        tick(); #1;
        chk("rstw_wait_busy", 32'(busy), 32'd1);
        tick(); rstn = 1'b0; #1;
        tick(); rstn = 1'b1; bk_wdone = 1'b1; #1;
        chk_reset_outputs("rstw");
        last_g   = N - 1;
        rd_model = '0;
        tick(); bk_wdone = 1'b0; bk_rdone = 1'b1; #1;
        chk("rstw_late_resp", 32'(resp_valid), 32'd0);
        chk("rstw_late_busy", 32'(busy), 32'd0);
        tick(); bk_rdone = 1'b0; #1;
        chk("rstw_idle_resp", 32'(resp_valid), 32'd0);
        set_req(2, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
        do_txn(2, 4'b0100, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);

        // randomized traffic against the arbitration model
        for (int t = 0; t < 80; t++) begin
            int w;
            int any;
            logic [31:0] rd;
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
                if (pend[i]) any = 1;
            end
            if (any == 0) new_req($urandom_range(0, N - 1));
            w  = pick(last_g);
            rd = $urandom;
            do_txn(w, onehot(w), $urandom_range(1, 5), rd, rd,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        tick(); drive(); #1;
        chk("final_ready", 32'(req_ready), 32'd0);
        tick(); #1;
        chk("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
